priority_request_scheduler: RTL and testbench
=============================================

# priority_request_scheduler

Sits directly upstream of the 4-input priority encoder and consumes its result. Captures single-cycle request pulses on four lines into a sticky pending register and drives that register into the encoder's `in`. It samples the encoder's `pos`, offers it to a consumer over a valid/ready handshake, and clears the granted pending bit on acceptance. Requests that hit an already-pending line are counted as merges.

## Interface
Parameters:
- CNT_W, 8, width of the saturating merge counter

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_in  input  4  request pulses, one bit per source; any pattern allowed each cycle
- pend  output  4  registered pending vector; drives encoder `in`
- enc_pos  input  2  encoder `pos`: index of the lowest set bit of `pend`, 0 when `pend`==0
- grant_valid  output  1  grant_pos is being offered
- grant_ready  input  1  consumer accepts the offer this cycle
- grant_pos  output  2  registered index of the granted source
- merge_cnt  output  CNT_W  saturating count of merged requests
- err  output  1  sticky: encoder returned an index whose pending bit was clear

## Operation
- Reset values: pend=0, grant_valid=0, grant_pos=0, merge_cnt=0, err=0, state=IDLE. Reset wins over every other event in the same cycle, including mid-handshake; any offer in flight is discarded.
- Pending update per bit i each cycle: pend_next[i] = req_in[i] | (pend[i] & ~clr[i]). clr[i]=1 only when the state is OFFER, grant_valid & grant_ready, and grant_pos==i.
- Simultaneous set and clear on the same bit: set wins and the bit stays 1. This is not a merge.
- Merge: req_in[i] & pend[i] & ~clr[i]. merge_cnt adds the number of merging bits that cycle (0..4) and saturates at 2^CNT_W-1. It never wraps.
- FSM states: IDLE, SAMPLE, OFFER.
  - IDLE: grant_valid=0. If pend!=0, go to SAMPLE; else stay in IDLE.
  - SAMPLE: grant_valid=0. If pend[enc_pos]==1, load grant_pos<=enc_pos and go to OFFER. Otherwise set err<=1, leave grant_pos unchanged, and go to IDLE.
  - OFFER: grant_valid=1 and grant_pos holds stable. If grant_ready=0, stay in OFFER. If grant_ready=1 and pend_next!=0, go to SAMPLE. If grant_ready=1 and pend_next==0, go to IDLE.
- New requests arriving during OFFER never change grant_pos. Re-prioritisation happens only in SAMPLE.
- err is cleared only by rst.

## Timing
- Request latency: req_in[i]=1 in cycle c gives pend[i]=1 in c+1. If the block was idle, the state is SAMPLE in c+2 and grant_valid=1 in c+3.
- Handshake completes in the OFFER cycle where grant_valid&grant_ready=1. The pend bit clears in the next cycle.
- Back-to-back grants: SAMPLE follows OFFER directly, so at most one grant every 2 cycles.
- grant_valid is never deasserted without a handshake, except on rst.
- The encoder is combinational. enc_pos must reflect the current pend within the same cycle.
- pend and grant_pos are outputs of flops. No combinational path runs from req_in or grant_ready to any output.

## Test plan
- Reset mid-offer: hold grant_ready=0 while in OFFER, then assert rst for 1 cycle -> next cycle pend=0, grant_valid=0, merge_cnt=0, err=0, state IDLE.
- Single request: pulse req_in=4'b0100 at cycle c -> pend=4'b0100 at c+1, grant_valid=1 with grant_pos=2 at c+3. Ready at c+3 -> pend=0 at c+4 and grant_valid=0.
- Priority order: pulse req_in=4'b1010, ready held at 1 -> grants pos=1, then pos=3, offered 2 cycles apart, then IDLE.
- Backpressure and late arrival: pend=4'b1000 in OFFER with grant_pos=3 and ready=0 for 5 cycles; pulse req_in=4'b0001 meanwhile -> grant_pos stays 3 throughout. After ready, the next grant is pos=0.
- Merge and collision: with pend[2]=1 not being granted, pulse req_in[2] 3 times -> merge_cnt=3. In the handshake cycle for pos=2, pulse req_in[2] -> pend[2] stays 1, merge_cnt is unchanged, and a second grant with pos=2 follows.
- Saturation and err: with CNT_W=2, cause 5 merges -> merge_cnt=3 and holds. Force enc_pos=1 while pend=4'b0100 in SAMPLE -> err=1, no grant offered, and err stays 1 until rst.

Source files
------------

// File: rtl/priority_request_scheduler_if.sv
// Grant handshake between the scheduler (master) and its consumer (slave).
interface priority_request_scheduler_if;
    logic       grant_valid;
    logic       grant_ready;
    logic [1:0] grant_pos;

    modport master (output grant_valid, output grant_pos, input grant_ready);
    modport slave  (input grant_valid, input grant_pos, output grant_ready);
endinterface

// File: rtl/priority_request_scheduler.sv
// Sticky request capture feeding an external 4-input priority encoder; the encoder
// result is sampled, offered over valid/ready, and the granted bit is cleared on accept.
module priority_request_scheduler #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    req_in,
    output logic [3:0]                    pend,
    input  logic [1:0]                    enc_pos,
    priority_request_scheduler_if.master  gnt,
    output logic [CNT_W-1:0]              merge_cnt,
    output logic                          err
);

    localparam int unsigned SUM_W = CNT_W + 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SAMPLE, OFFER} state_e;

    state_e             state_q, state_d;
    logic [3:0]         pend_q, pend_d;
    logic               grant_valid_q, grant_valid_d;
    logic [1:0]         grant_pos_q, grant_pos_d;
    logic [CNT_W-1:0]   merge_cnt_q, merge_cnt_d;
    logic               err_q, err_d;

    logic               hs;
    logic [3:0]         clr;
    logic [3:0]         merge_bits;
    logic [2:0]         merge_num;
    logic [SUM_W-1:0]   merge_sum;

    // Pending vector update and saturating merge accounting; a set beats a clear.
    always_comb begin
        hs         = (state_q == OFFER) && grant_valid_q && gnt.grant_ready;
        clr        = hs ? 4'(4'b0001 << grant_pos_q) : 4'b0000;
        pend_d     = req_in | (pend_q & ~clr);
        merge_bits = req_in & pend_q & ~clr;
        merge_num  = 3'd0;
        for (int i = 0; i < 4; i++) begin
            merge_num = merge_num + 3'(merge_bits[i]);
        end
        merge_sum  = SUM_W'(merge_cnt_q) + SUM_W'(merge_num);
        if (merge_sum > SUM_W'(CNT_MAX)) begin
            merge_cnt_d = CNT_MAX;
        end else begin
            merge_cnt_d = CNT_W'(merge_sum);
        end
    end

    // Next-state, grant capture and error detection.
    always_comb begin
        state_d     = state_q;
        grant_pos_d = grant_pos_q;
        err_d       = err_q;
        unique case (state_q)
            IDLE: begin
                if (pend_q != 4'b0000) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (pend_q[enc_pos]) begin
                    grant_pos_d = enc_pos;
                    state_d     = OFFER;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            OFFER: begin
                if (gnt.grant_ready) begin
                    state_d = (pend_d != 4'b0000) ? SAMPLE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        grant_valid_d = (state_d == OFFER);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pend_q        <= 4'b0000;
            grant_valid_q <= 1'b0;
            grant_pos_q   <= 2'd0;
            merge_cnt_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            grant_valid_q <= grant_valid_d;
            grant_pos_q   <= grant_pos_d;
            merge_cnt_q   <= merge_cnt_d;
            err_q         <= err_d;
        end
    end

    assign pend            = pend_q;
    assign gnt.grant_valid = grant_valid_q;
    assign gnt.grant_pos   = grant_pos_q;
    assign merge_cnt       = merge_cnt_q;
    assign err             = err_q;

endmodule

// File: tb/tb_priority_request_scheduler.sv
// Directed bench: main DUT (CNT_W=8) plus a CNT_W=2 copy on the same stimulus for saturation.
module tb_priority_request_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_in = 4'b0000;
    logic       force_en = 1'b0;

    logic [3:0] pend, pend2;
    logic [1:0] enc_pos, enc_pos2;
    logic [7:0] merge_cnt;
    logic [1:0] merge_cnt2;
    logic       err, err2;

    priority_request_scheduler_if bus ();
    priority_request_scheduler_if bus2 ();

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [1:0] enc(input logic [3:0] v);
        if (v[0]) return 2'd0;
        if (v[1]) return 2'd1;
        if (v[2]) return 2'd2;
        if (v[3]) return 2'd3;
        return 2'd0;
    endfunction

    assign enc_pos          = force_en ? 2'd1 : enc(pend);
    assign enc_pos2         = force_en ? 2'd1 : enc(pend2);
    assign bus2.grant_ready = bus.grant_ready;

    priority_request_scheduler #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .pend(pend), .enc_pos(enc_pos),
        .gnt(bus), .merge_cnt(merge_cnt), .err(err)
    );

    priority_request_scheduler #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req_in(req_in), .pend(pend2), .enc_pos(enc_pos2),
        .gnt(bus2), .merge_cnt(merge_cnt2), .err(err2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (!(pend == 4'b0000 && !bus.grant_valid) && n < 20) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 20), 32'd1);
        bus.grant_ready = 1'b0;
    endtask

    // Scoreboard monitor: every accepted grant must match the next expected position.
    always @(negedge clk) begin
        if (!rst && bus.grant_valid && bus.grant_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL grant_unexpected: got pos %0d with empty queue", bus.grant_pos);
            end else begin
                chk("grant_pos", 32'(bus.grant_pos), 32'(exp_q.pop_front()));
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.grant_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_pend", 32'(pend), 32'd0);
        chk("rst_valid", 32'(bus.grant_valid), 32'd0);
        chk("rst_pos", 32'(bus.grant_pos), 32'd0);
        chk("rst_merge", 32'(merge_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Reset mid-offer discards the offer and clears everything.
        req_in = 4'b0001; tick(); req_in = 4'b0000;
        tick(); tick();
        chk("mid_offer_valid", 32'(bus.grant_valid), 32'd1);
        req_in = 4'b0001; tick(); req_in = 4'b0000;
        chk("mid_offer_merge", 32'(merge_cnt), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_pend", 32'(pend), 32'd0);
        chk("mid_rst_valid", 32'(bus.grant_valid), 32'd0);
        chk("mid_rst_merge", 32'(merge_cnt), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        tick();
        chk("mid_rst_idle", 32'(bus.grant_valid), 32'd0);

        // Single request: latency c+1 pend, c+3 offer, clear at c+4.
        req_in = 4'b0100; tick(); req_in = 4'b0000;
        chk("single_pend", 32'(pend), 32'h4);
        tick();
        chk("single_sample_valid", 32'(bus.grant_valid), 32'd0);
        tick();
        chk("single_valid", 32'(bus.grant_valid), 32'd1);
        chk("single_pos", 32'(bus.grant_pos), 32'd2);
        exp_q.push_back(2);
        bus.grant_ready = 1'b1; tick(); bus.grant_ready = 1'b0;
        chk("single_clr_pend", 32'(pend), 32'd0);
        chk("single_clr_valid", 32'(bus.grant_valid), 32'd0);

        // Priority order, back-to-back grants two cycles apart.
        exp_q.push_back(1); exp_q.push_back(3);
        bus.grant_ready = 1'b1;
        req_in = 4'b1010; tick(); req_in = 4'b0000;
        tick(); tick();
        chk("prio_first_valid", 32'(bus.grant_valid), 32'd1);
        chk("prio_first_pos", 32'(bus.grant_pos), 32'd1);
        tick();
        chk("prio_gap_valid", 32'(bus.grant_valid), 32'd0);
        chk("prio_gap_pend", 32'(pend), 32'h8);
        tick();
        chk("prio_second_valid", 32'(bus.grant_valid), 32'd1);
        chk("prio_second_pos", 32'(bus.grant_pos), 32'd3);
        tick();
        chk("prio_idle_valid", 32'(bus.grant_valid), 32'd0);
        chk("prio_idle_pend", 32'(pend), 32'd0);
        bus.grant_ready = 1'b0;

        // Backpressure with a late higher-priority arrival.
        exp_q.push_back(3); exp_q.push_back(0);
        req_in = 4'b1000; tick(); req_in = 4'b0000;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            req_in = (i == 1) ? 4'b0001 : 4'b0000;
            tick();
            chk("bp_pos_hold", 32'(bus.grant_pos), 32'd3);
            chk("bp_valid_hold", 32'(bus.grant_valid), 32'd1);
        end
        req_in = 4'b0000;
        chk("bp_pend", 32'(pend), 32'h9);
        bus.grant_ready = 1'b1; tick();
        chk("bp_sample_valid", 32'(bus.grant_valid), 32'd0);
        tick();
        chk("bp_next_pos", 32'(bus.grant_pos), 32'd0);
        chk("bp_next_valid", 32'(bus.grant_valid), 32'd1);
        tick();
        bus.grant_ready = 1'b0;
        chk("bp_done_pend", 32'(pend), 32'd0);

        // Merges while pend[2] waits, then a collision in the handshake cycle.
        exp_q.push_back(2); exp_q.push_back(2);
        req_in = 4'b0100; tick(); req_in = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            req_in = 4'b0100; tick(); req_in = 4'b0000; tick();
        end
        chk("merge_cnt3", 32'(merge_cnt), 32'd3);
        chk("merge_cnt3_small", 32'(merge_cnt2), 32'd3);
        chk("merge_offer_pos", 32'(bus.grant_pos), 32'd2);
        bus.grant_ready = 1'b1; req_in = 4'b0100; tick(); req_in = 4'b0000;
        chk("coll_pend", 32'(pend), 32'h4);
        chk("coll_merge", 32'(merge_cnt), 32'd3);
        tick();
        chk("coll_regrant_valid", 32'(bus.grant_valid), 32'd1);
        chk("coll_regrant_pos", 32'(bus.grant_pos), 32'd2);
        tick();
        bus.grant_ready = 1'b0;
        chk("coll_done_pend", 32'(pend), 32'd0);

        // Saturation: two more merges -> 5 on the wide counter, 3 on the narrow one.
        req_in = 4'b0010; tick(); req_in = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            req_in = 4'b0010; tick(); req_in = 4'b0000; tick();
        end
        chk("sat_wide", 32'(merge_cnt), 32'd5);
        chk("sat_narrow", 32'(merge_cnt2), 32'd3);
        exp_q.push_back(1);
        bus.grant_ready = 1'b1;
        drain();

        // Encoder disagreement in SAMPLE raises sticky err without an offer.
        force_en = 1'b1;
        req_in = 4'b0100; tick(); req_in = 4'b0000;
        tick(); tick();
        chk("err_set", 32'(err), 32'd1);
        chk("err_set_small", 32'(err2), 32'd1);
        chk("err_no_offer", 32'(bus.grant_valid), 32'd0);
        chk("err_pos_kept", 32'(bus.grant_pos), 32'd1);
        force_en = 1'b0;
        exp_q.push_back(2);
        bus.grant_ready = 1'b1;
        drain();
        chk("err_sticky", 32'(err), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);
        chk("err_cleared_merge_small", 32'(merge_cnt2), 32'd0);

        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
